// File: rtl/type_dispatch_if.sv
// Decoder-to-dispatcher handshake plus the per-unit enable/done bundle.
interface type_dispatch_if #(
  parameter int unsigned TYPE_W    = 3,
  parameter int unsigned NUM_UNITS = 4
);
  localparam int unsigned UID_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic                 id_valid;
  logic [TYPE_W-1:0]    id_type;
  logic                 id_ready;
  logic [NUM_UNITS-1:0] unit_done;
  logic [NUM_UNITS-1:0] unit_enb;
  logic [UID_W-1:0]     cur_unit;
  logic                 busy;
  logic                 illegal;
  logic                 timeout;

  modport master (
    output id_valid, id_type, unit_done,
    input  id_ready, unit_enb, cur_unit, busy, illegal, timeout
  );

  modport slave (
    input  id_valid, id_type, unit_done,
    output id_ready, unit_enb, cur_unit, busy, illegal, timeout
  );
endinterface

// File: rtl/type_dispatch.sv
// Instruction-type dispatcher: maps a decoded type to a one-hot unit enable,
// holds it until that unit reports done, flags unmapped types and hung units.
module type_dispatch #(
  parameter int unsigned TYPE_W    = 3,
  parameter int unsigned NUM_UNITS = 4,
  parameter logic [(2**TYPE_W)*(((NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1) + 1)-1:0] MAP =
    24'b110_000_000_111_100_100_101_000,
  parameter int unsigned NOP_TYPE  = 0,
  parameter int unsigned TIMEOUT   = 64
) (
  input logic            clk,
  input logic            rst_n,
  type_dispatch_if.slave bus
);
  localparam int unsigned UID_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned ENT_W = UID_W + 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [NUM_UNITS-1:0] enb_q, enb_d;
  logic [UID_W-1:0]     cur_q, cur_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;
  logic [ENT_W-1:0]     entry;
  logic                 hit;
  logic                 done_cur;
  logic                 ready;
  logic                 hs;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      enb_q     <= '0;
      cur_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      enb_q     <= enb_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, map lookup and handshake
  always_comb begin
    state_d   = state_q;
    enb_d     = enb_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    timeout_d = 1'b0;

    entry    = MAP[ENT_W*32'(bus.id_type) +: ENT_W];
    hit      = entry[ENT_W-1] && (32'(entry[UID_W-1:0]) < NUM_UNITS);
    // enb_q is one-hot on cur_unit while busy, so this isolates done[cur_unit]
    done_cur = |(bus.unit_done & enb_q);
    ready    = rst_n && ((state_q == IDLE) || done_cur);
    hs       = bus.id_valid && ready;

    case (state_q)
      BUSY: begin
        if (done_cur) begin
          state_d = IDLE;
          enb_d   = '0;
          cur_d   = '0;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d   = IDLE;
          enb_d     = '0;
          cur_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        enb_d   = '0;
        cur_d   = '0;
      end
    endcase

    // A handshake is only possible when idle or the current unit completes
    if (hs) begin
      if (hit) begin
        state_d = BUSY;
        enb_d   = NUM_UNITS'(1) << entry[UID_W-1:0];
        cur_d   = entry[UID_W-1:0];
        cnt_d   = '0;
      end else begin
        illegal_d = (32'(bus.id_type) != NOP_TYPE);
      end
    end

    busy_d = (state_d == BUSY);
  end

  assign bus.id_ready = ready;
  assign bus.unit_enb = enb_q;
  assign bus.cur_unit = cur_q;
  assign bus.busy     = busy_q;
  assign bus.illegal  = illegal_q;
  assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_type_dispatch.sv
// Bench for type_dispatch: directed scenarios plus random traffic, all
// checked cycle by cycle against a behavioural unit-occupancy model.
module tb_type_dispatch;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [63:0] MAP_B = (64'(4'b1101) << 36) | (64'(4'b1111) << 40);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  type_dispatch_if #(.TYPE_W(3), .NUM_UNITS(4)) bus_a ();
  type_dispatch_if #(.TYPE_W(4), .NUM_UNITS(6)) bus_b ();

  type_dispatch #(.TIMEOUT(TIMEOUT)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  type_dispatch #(.TYPE_W(4), .NUM_UNITS(6), .MAP(MAP_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Type -> unit index from the default table; -1 means unmapped
  int map_a [8] = '{-1, 1, 0, 0, 3, -1, -1, 2};
  int exp_sweep [8] = '{0, 2, 1, 1, 8, 0, 0, 4};

  int         m_unit = -1;
  int         m_age  = 0;
  logic [3:0] e_enb  = '0;
  int         e_cur  = 0;
  bit         e_ill  = 1'b0;
  bit         e_to   = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus on dut_a; entered and left at a falling edge
  task automatic cycle(input bit rst, input bit valid, input int typ, input logic [3:0] done);
    bit exp_ready;
    int u;
    rst_n          = rst;
    bus_a.id_valid = valid;
    bus_a.id_type  = 3'(typ);
    bus_a.unit_done = done;
    #1;
    exp_ready = rst && ((m_unit < 0) || done[m_unit[1:0]]);
    chk("id_ready", 32'(bus_a.id_ready), 32'(exp_ready));

    e_ill = 1'b0;
    e_to  = 1'b0;
    if (!rst) begin
      m_unit = -1;
      m_age  = 0;
    end else if ((m_unit >= 0) && !done[m_unit[1:0]]) begin
      if ((TIMEOUT != 0) && (m_age == int'(TIMEOUT))) begin
        m_unit = -1;
        e_to   = 1'b1;
      end else begin
        m_age++;
      end
    end else begin
      m_unit = -1;
      if (valid) begin
        u = map_a[typ];
        if (u >= 0) begin
          m_unit = u;
          m_age  = 1;
        end else begin
          e_ill = (typ != 0);
        end
      end
    end
    e_enb = (m_unit >= 0) ? 4'(1 << m_unit) : 4'b0000;
    e_cur = (m_unit >= 0) ? m_unit : 0;

    @(posedge clk);
    @(negedge clk);
    chk("unit_enb", 32'(bus_a.unit_enb), 32'(e_enb));
    chk("cur_unit", 32'(bus_a.cur_unit), 32'(e_cur));
    chk("busy",     32'(bus_a.busy),     32'(m_unit >= 0));
    chk("illegal",  32'(bus_a.illegal),  32'(e_ill));
    chk("timeout",  32'(bus_a.timeout),  32'(e_to));
  endtask

  int n_on;
  int n_to;

  initial begin
    rst_n           = 1'b0;
    bus_a.id_valid  = 1'b0;
    bus_a.id_type   = '0;
    bus_a.unit_done = '0;
    bus_b.id_valid  = 1'b0;
    bus_b.id_type   = '0;
    bus_b.unit_done = '0;
    @(negedge clk);

    // Reset held with a pending request
    repeat (3) cycle(1'b0, 1'b1, 2, 4'b0000);
    chk("b_reset_enb", 32'(bus_b.unit_enb), 32'd0);

    cycle(1'b1, 1'b1, 2, 4'b0000);
    chk("first_alu_enb", 32'(bus_a.unit_enb), 32'h1);
    cycle(1'b1, 1'b0, 0, 4'b0001);
    cycle(1'b1, 1'b0, 0, 4'b0000);

    // Sweep every type, done two cycles after the enable
    for (int t = 0; t < 8; t++) begin
      cycle(1'b1, 1'b1, t, 4'b0000);
      chk("sweep_enb", 32'(bus_a.unit_enb), 32'(exp_sweep[t]));
      chk("sweep_illegal", 32'(bus_a.illegal), 32'((t == 5) || (t == 6)));
      cycle(1'b1, 1'b0, 0, 4'b0000);
      cycle(1'b1, 1'b0, 0, e_enb);
      cycle(1'b1, 1'b0, 0, 4'b0000);
    end

    // Back-to-back with a stray done from another unit
    cycle(1'b1, 1'b1, 7, 4'b0000);
    cycle(1'b1, 1'b1, 1, 4'b1000);
    chk("stray_done_enb", 32'(bus_a.unit_enb), 32'h4);
    cycle(1'b1, 1'b1, 1, 4'b0100);
    chk("b2b_enb", 32'(bus_a.unit_enb), 32'h2);
    cycle(1'b1, 1'b0, 0, 4'b0010);

    // Full throughput with done held high
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, $urandom_range(0, 7), 4'b1111);
    cycle(1'b1, 1'b0, 0, 4'b1111);

    // Hung DMA unit
    cycle(1'b1, 1'b1, 4, 4'b0000);
    n_on = (bus_a.unit_enb == 4'b1000) ? 1 : 0;
    n_to = 0;
    repeat (70) begin
      cycle(1'b1, 1'b0, 0, 4'b0000);
      if (bus_a.unit_enb == 4'b1000) n_on++;
      if (bus_a.timeout) n_to++;
    end
    chk("timeout_len", 32'(n_on), 32'd64);
    chk("timeout_pulses", 32'(n_to), 32'd1);

    // Done on the last allowed cycle wins over the timeout
    cycle(1'b1, 1'b1, 4, 4'b0000);
    repeat (63) cycle(1'b1, 1'b0, 0, 4'b0000);
    cycle(1'b1, 1'b0, 0, 4'b1000);
    chk("late_done_timeout", 32'(bus_a.timeout), 32'd0);

    // Wider variant with a custom map
    bus_b.id_valid = 1'b1;
    bus_b.id_type  = 4'd9;
    cycle(1'b1, 1'b0, 0, 4'b0000);
    chk("b_enb_unit5", 32'(bus_b.unit_enb), 32'h20);
    chk("b_cur_unit5", 32'(bus_b.cur_unit), 32'd5);
    bus_b.id_type   = 4'd10;
    bus_b.unit_done = 6'b100000;
    cycle(1'b1, 1'b0, 0, 4'b0000);
    chk("b_bad_index_enb", 32'(bus_b.unit_enb), 32'd0);
    chk("b_bad_index_illegal", 32'(bus_b.illegal), 32'd1);
    bus_b.id_valid  = 1'b0;
    bus_b.unit_done = '0;
    cycle(1'b1, 1'b0, 0, 4'b0000);
    chk("b_illegal_pulse", 32'(bus_b.illegal), 32'd0);

    // Reset while the ALU is busy
    cycle(1'b1, 1'b1, 2, 4'b0000);
    cycle(1'b0, 1'b0, 0, 4'b0000);
    chk("mid_reset_enb", 32'(bus_a.unit_enb), 32'd0);
    cycle(1'b1, 1'b1, 3, 4'b0000);
    chk("post_reset_enb", 32'(bus_a.unit_enb), 32'h1);
    cycle(1'b1, 1'b0, 0, 4'b0001);

    // Random traffic
    repeat (1500) begin
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
